// File: rtl/addsub_serial_keyed.sv
// addsub_serial_keyed: keyed digit-serial adder/subtractor.
//   Computes a+b (mode=0) or a-b (mode=1) DIGIT bits per cycle, LSB digit
//   first, after PRE_DELAY dead cycles. The key is checked once on the start
//   edge; a wrong key flips the initial carry and nothing else, so timing and
//   status are identical but the result is off by one.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   en    - start in IDLE, release in DONE, ignored while busy
//   a, b  - operands (WIDTH), sampled on the start edge
//   mode  - 0 = add, 1 = subtract, sampled on the start edge
//   key   - unlock key (KEY_W), compared on the start edge only
//   out   - result register (WIDTH)
//   cout  - final carry; in subtract mode 1 means no borrow
//   busy  - high in PRE and CALC
//   done  - high in DONE
module addsub_serial_keyed #(
  parameter int               WIDTH     = 8,
  parameter int               DIGIT     = 1,
  parameter int               PRE_DELAY = 1,
  parameter int               KEY_W     = 8,
  parameter logic [KEY_W-1:0] KEY       = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic [KEY_W-1:0] key,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int N       = WIDTH / DIGIT;
  localparam int CNT_MAX = (N > PRE_DELAY) ? N : PRE_DELAY;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] LAST_C   = CW'(N - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] a_r, b_r, out_r, out_next_s;
  logic             carry_r, cout_r, busy_r, done_r;
  logic             busy_next_s, done_next_s;
  logic [CW-1:0]    count_r;
  logic [DIGIT:0]   sum_s;

  // One digit of the sum: low digits of both operands plus the running carry.
  assign sum_s = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_r};

  // New digit enters at the MSB end so the first (LSB) digit ends up at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_full
      assign out_next_s = sum_s[DIGIT-1:0];
    end else begin : g_shift
      assign out_next_s = {sum_s[DIGIT-1:0], out_r[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register, with busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_next_s = (PRE_DELAY > 0) ? PRE : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      PRE: begin
        if (count_r == PRE_LAST) begin
          state_next_s = CALC;
        end else begin
          state_next_s = PRE;
        end
      end
      CALC: begin
        if (count_r == LAST_C) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (en) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Status decode of the state being entered.
  always_comb begin
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    case (state_next_s)
      PRE:     busy_next_s = 1'b1;
      CALC:    busy_next_s = 1'b1;
      DONE:    done_next_s = 1'b1;
      default: begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, digit-serial accumulate, result/carry hold.
  // The initial carry alone encodes both subtract (+1 for two's complement)
  // and the key check, so neither mode nor the key result is kept afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      count_r <= '0;
      out_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en) begin
            a_r     <= a;
            b_r     <= mode ? ~b : b;
            carry_r <= mode ^ (key != KEY);
            out_r   <= '0;
            count_r <= '0;
          end
        end
        PRE: begin
          if (count_r == PRE_LAST) begin
            count_r <= '0;
          end else begin
            count_r <= count_r + ONE_C;
          end
        end
        CALC: begin
          out_r   <= out_next_s;
          carry_r <= sum_s[DIGIT];
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          count_r <= count_r + ONE_C;
          if (count_r == LAST_C) begin
            cout_r <= sum_s[DIGIT];
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign out  = out_r;
  assign cout = cout_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_addsub_serial_keyed.sv
// Directed bench for addsub_serial_keyed: an 8-bit default instance driven
// from a vector table plus hand-written reset and operand-toggle sequences,
// and a 16-bit / 4-bit-digit / no-dead-cycle instance.
module tb_addsub_serial_keyed;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [7:0] key;
    logic [7:0] eo;
    logic       ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       en8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00, key8 = 8'h00, out8;
  logic       cout8, busy8, done8;

  logic        en16 = 1'b0, mode16 = 1'b0;
  logic [15:0] a16 = 16'h0, b16 = 16'h0, out16;
  logic [7:0]  key16 = 8'hA5;
  logic        cout16, busy16, done16;

  int total = 0;
  int bad   = 0;

  vec_t tbl [10];

  always #5 clk = ~clk;

  addsub_serial_keyed d8 (
    .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8), .mode(mode8),
    .key(key8), .out(out8), .cout(cout8), .busy(busy8), .done(done8)
  );

  addsub_serial_keyed #(.WIDTH(16), .DIGIT(4), .PRE_DELAY(0)) d16 (
    .clk(clk), .rst(rst), .en(en16), .a(a16), .b(b16), .mode(mode16),
    .key(key16), .out(out16), .cout(cout16), .busy(busy16), .done(done16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One 8-bit operation: start, count edges to done, check result, hold, release.
  task automatic run8(input vec_t v, input bit toggle, input string name);
    int edges, busy_cnt;
    @(negedge clk);
    a8 = v.a; b8 = v.b; mode8 = v.mode; key8 = v.key; en8 = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    busy_cnt = busy8 ? 1 : 0;
    @(negedge clk);
    en8 = 1'b0;
    while (!done8 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
      if (busy8) busy_cnt++;
      if (!done8 && toggle) begin
        @(negedge clk);
        en8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        mode8 = 1'($urandom); key8 = 8'($urandom);
      end
    end
    chk({name, "_done_seen"}, done8, 1);
    chk({name, "_latency"}, edges, 10);
    chk({name, "_busy_cycles"}, busy_cnt, 9);
    chk({name, "_out"}, out8, v.eo);
    chk({name, "_cout"}, cout8, v.ec);
    @(negedge clk);
    en8 = 1'b0;
    @(posedge clk); #1;
    chk({name, "_done_hold"}, done8, 1);
    @(negedge clk);
    en8 = 1'b1;
    @(posedge clk); #1;
    chk({name, "_release_done"}, done8, 0);
    chk({name, "_release_busy"}, busy8, 0);
    chk({name, "_release_out"}, out8, v.eo);
    @(negedge clk);
    en8 = 1'b0;
  endtask

  // One 16-bit operation on the 4-bit-digit instance.
  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic m,
                       input logic [15:0] eo, input logic ec, input string name);
    int edges;
    @(negedge clk);
    a16 = av; b16 = bv; mode16 = m; en16 = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    @(negedge clk);
    en16 = 1'b0;
    while (!done16 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({name, "_done_seen"}, done16, 1);
    chk({name, "_latency"}, edges, 5);
    chk({name, "_out"}, out16, eo);
    chk({name, "_cout"}, cout16, ec);
    @(negedge clk);
    en16 = 1'b1;
    @(posedge clk); #1;
    chk({name, "_release"}, done16, 0);
    @(negedge clk);
    en16 = 1'b0;
  endtask

  initial begin
    //            a      b      mode  key    out    cout
    tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'hA5, 8'h96, 1'b0};
    tbl[1] = '{8'h3C, 8'h5A, 1'b1, 8'hA5, 8'hE2, 1'b0};
    tbl[2] = '{8'h5A, 8'h3C, 1'b1, 8'hA5, 8'h1E, 1'b1};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'hA5, 8'h00, 1'b1};
    tbl[4] = '{8'h3C, 8'h5A, 1'b0, 8'h00, 8'h97, 1'b0};
    tbl[5] = '{8'h3C, 8'h5A, 1'b1, 8'h00, 8'hE1, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'hA5, 8'h00, 1'b1};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0};
    tbl[8] = '{8'hFF, 8'hFF, 1'b0, 8'hA5, 8'hFE, 1'b1};
    tbl[9] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h01, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out8, 8'h00);
    chk("rst_cout", cout8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run8(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Reset mid-CALC: a=FF,b=00 add shifts ones in from the top.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; mode8 = 1'b0; key8 = 8'hA5; en8 = 1'b1;
    @(posedge clk);            // start
    @(negedge clk); en8 = 1'b0;
    repeat (3) @(posedge clk); // PRE, CALC1, CALC2
    #1;
    chk("midrst_partial", out8, 8'hC0);
    chk("midrst_busy_before", busy8, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out", out8, 8'h00);
    chk("midrst_cout", cout8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_idle_busy", busy8, 0);

    // Fresh run with inputs churning while busy.
    run8(tbl[0], 1'b1, "toggle");

    // Wide-digit instance, no dead cycles.
    run16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, "w16_add");
    run16(16'h1234, 16'h0FFF, 1'b1, 16'h0235, 1'b1, "w16_sub");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
